branch_update_arbiter: RTL and testbench

// - Collects branch resolutions from N_REQ execution-unit branch ports.
// - Holds each in a 1-entry buffer; each cycle forwards the oldest pending one (in ROB order)
//   as the single predictor_update stream consumed by the flush controller and branch predictor.
// - Squashes buffered resolutions younger than a flushing branch, so stale wrong-path updates never issue.

---
 rtl/branch_update_arbiter_pkg.sv | 22 ++
 rtl/branch_update_arbiter_oldest_select.sv | 35 +++
 rtl/branch_update_arbiter.sv | 110 +++++++++++
 tb/tb_branch_update_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_update_arbiter_pkg.sv
// rtl/branch_update_arbiter_pkg.sv - shared predictor_update type and ROB age helper
package branch_update_arbiter_pkg;

  localparam int ROB_INDEX_BITS = 3;

  typedef struct packed {
    logic                      valid_jump;
    logic [ROB_INDEX_BITS-1:0] rob_ticket;
    logic [3:0]                rat_id;
    logic                      jump_taken;
    logic [11:0]               jump_target;
  } pu_t;

  // Distance from the ROB head; wraps naturally at the ticket width.
  function automatic logic [ROB_INDEX_BITS-1:0] rob_age(
    input logic [ROB_INDEX_BITS-1:0] ticket,
    input logic [ROB_INDEX_BITS-1:0] head
  );
    return ticket - head;
  endfunction

endpackage

// File: rtl/branch_update_arbiter_oldest_select.sv
// rtl/branch_update_arbiter_oldest_select.sv - picks the pending entry with the smallest ROB age
module branch_update_arbiter_oldest_select
  import branch_update_arbiter_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int IDX_BITS = 1
) (
  input  logic [N_REQ-1:0]          i_pending,
  input  logic [ROB_INDEX_BITS-1:0] i_age [N_REQ],
  output logic [N_REQ-1:0]          o_grant,
  output logic [IDX_BITS-1:0]       o_index,
  output logic                      o_any
);

  logic [ROB_INDEX_BITS-1:0] w_best_age;

  // Strict less-than keeps the lowest index on equal ages.
  always_comb begin
    o_grant    = '0;
    o_index    = '0;
    o_any      = 1'b0;
    w_best_age = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (i_pending[i] && (!o_any || (i_age[i] < w_best_age))) begin
        o_any      = 1'b1;
        w_best_age = i_age[i];
        o_index    = IDX_BITS'(i);
      end
    end
    if (o_any) begin
      o_grant[o_index] = 1'b1;
    end
  end

endmodule

// File: rtl/branch_update_arbiter.sv
// rtl/branch_update_arbiter.sv - per-port branch update buffers merged oldest-first with flush squash
module branch_update_arbiter
  import branch_update_arbiter_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int CNT_BITS = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  pu_t                       req_update [N_REQ],
  output logic [N_REQ-1:0]          req_ready,
  input  logic [ROB_INDEX_BITS-1:0] rob_head,
  input  logic                      out_ready,
  output pu_t                       out_update,
  input  logic                      flush_valid,
  input  logic [ROB_INDEX_BITS-1:0] flush_ticket,
  output logic [CNT_BITS-1:0]       squash_count,
  output logic [CNT_BITS-1:0]       issue_count
);

  localparam int IDX_BITS = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]          r_pending;
  pu_t                       r_payload [N_REQ];
  logic [CNT_BITS-1:0]       r_squash_count;
  logic [CNT_BITS-1:0]       r_issue_count;

  logic [ROB_INDEX_BITS-1:0] w_age [N_REQ];
  logic [N_REQ-1:0]          w_grant;
  logic [IDX_BITS-1:0]       w_index;
  logic                      w_any;
  logic                      w_pop;
  logic [N_REQ-1:0]          w_capture;
  logic [N_REQ-1:0]          w_keep;
  logic [N_REQ-1:0]          w_squash;
  logic [N_REQ-1:0]          w_next_pending;
  pu_t                       w_next_payload [N_REQ];
  logic [ROB_INDEX_BITS-1:0] w_flush_age;
  logic [CNT_BITS:0]         w_squash_sum;
  logic [CNT_BITS:0]         w_issue_sum;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_age[i] = rob_age(r_payload[i].rob_ticket, rob_head);
    end
  end

  branch_update_arbiter_oldest_select #(
    .N_REQ    (N_REQ),
    .IDX_BITS (IDX_BITS)
  ) u_oldest_select (
    .i_pending (r_pending),
    .i_age     (w_age),
    .o_grant   (w_grant),
    .o_index   (w_index),
    .o_any     (w_any)
  );

  // Output depends only on registered state, never on flush_*.
  always_comb begin
    out_update = '0;
    if (w_any) begin
      out_update            = r_payload[w_index];
      out_update.valid_jump = 1'b1;
    end
  end

  assign w_pop     = w_any & out_ready;
  assign req_ready = ~r_pending | (w_grant & {N_REQ{out_ready}});
  assign w_capture = req_valid & req_ready;

  assign w_flush_age = rob_age(flush_ticket, rob_head);

  // Squash is applied to the next-state view, so same-cycle captures are covered.
  always_comb begin
    w_squash_sum = {1'b0, r_squash_count};
    for (int i = 0; i < N_REQ; i++) begin
      w_next_payload[i] = w_capture[i] ? req_update[i] : r_payload[i];
      w_keep[i]         = w_capture[i] | (r_pending[i] & ~(w_grant[i] & w_pop));
      w_squash[i]       = flush_valid & w_keep[i] &
                          (rob_age(w_next_payload[i].rob_ticket, rob_head) > w_flush_age);
      w_next_pending[i] = w_keep[i] & ~w_squash[i];
      w_squash_sum      = w_squash_sum + {{CNT_BITS{1'b0}}, w_squash[i]};
    end
    w_issue_sum = {1'b0, r_issue_count} + {{CNT_BITS{1'b0}}, w_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending      <= '0;
      r_squash_count <= '0;
      r_issue_count  <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        r_payload[i] <= '0;
      end
    end else begin
      r_pending <= w_next_pending;
      for (int i = 0; i < N_REQ; i++) begin
        r_payload[i] <= w_next_payload[i];
      end
      r_squash_count <= w_squash_sum[CNT_BITS] ? {CNT_BITS{1'b1}} : w_squash_sum[CNT_BITS-1:0];
      r_issue_count  <= w_issue_sum[CNT_BITS]  ? {CNT_BITS{1'b1}} : w_issue_sum[CNT_BITS-1:0];
    end
  end

  assign squash_count = r_squash_count;
  assign issue_count  = r_issue_count;

endmodule

// File: tb/tb_branch_update_arbiter.sv
// tb/tb_branch_update_arbiter.sv - randomized and directed checks against a behavioural model
module tb_branch_update_arbiter;
  import branch_update_arbiter_pkg::*;

  localparam int CNT_BITS = 4;
  localparam int CNT_MAX  = 15;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [1:0]                req_valid;
  pu_t                       req_update [2];
  logic [1:0]                req_ready;
  logic [ROB_INDEX_BITS-1:0] rob_head;
  logic                      out_ready;
  pu_t                       out_update;
  logic                      flush_valid;
  logic [ROB_INDEX_BITS-1:0] flush_ticket;
  logic [CNT_BITS-1:0]       squash_count;
  logic [CNT_BITS-1:0]       issue_count;

  int checks = 0;
  int errors = 0;

  bit  m_pend [2];
  pu_t m_pay  [2];
  int  m_iss;
  int  m_sq;

  always #5 clk = ~clk;

  branch_update_arbiter #(.N_REQ(2), .CNT_BITS(CNT_BITS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_update   (req_update),
    .req_ready    (req_ready),
    .rob_head     (rob_head),
    .out_ready    (out_ready),
    .out_update   (out_update),
    .flush_valid  (flush_valid),
    .flush_ticket (flush_ticket),
    .squash_count (squash_count),
    .issue_count  (issue_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int age(input logic [2:0] t, input logic [2:0] h);
    return (int'(t) - int'(h) + 8) % 8;
  endfunction

  function automatic pu_t mk(input int t);
    pu_t p;
    p             = '0;
    p.valid_jump  = 1'b1;
    p.rob_ticket  = 3'(t);
    p.rat_id      = 4'(t + 1);
    p.jump_taken  = t[0];
    p.jump_target = 12'(12'h100 + t * 3);
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 0;
      m_pay[i]  = '0;
    end
    m_iss = 0;
    m_sq  = 0;
  endtask

  task automatic idle();
    req_valid   = 2'b00;
    req_update[0] = '0;
    req_update[1] = '0;
    out_ready   = 1'b1;
    flush_valid = 1'b0;
    flush_ticket = '0;
  endtask

  // Called just after a negedge with inputs driven; compares, then advances one clock.
  task automatic tick();
    int   best;
    pu_t  e_out;
    logic [1:0] e_rdy;
    bit   popped;
    bit   n_pend [2];
    pu_t  n_pay  [2];
    #1;
    best = -1;
    for (int i = 0; i < 2; i++)
      if (m_pend[i] && (best < 0 || age(m_pay[i].rob_ticket, rob_head) < age(m_pay[best].rob_ticket, rob_head)))
        best = i;
    e_out = '0;
    if (best >= 0) begin
      e_out = m_pay[best];
      e_out.valid_jump = 1'b1;
    end
    for (int i = 0; i < 2; i++) e_rdy[i] = !m_pend[i] || (best == i && out_ready);
    check("out_update", 64'(out_update), 64'(e_out));
    check("req_ready", 64'(req_ready), 64'(e_rdy));
    check("issue_count", 64'(issue_count), 64'(m_iss));
    check("squash_count", 64'(squash_count), 64'(m_sq));
    popped = (best >= 0) && out_ready;
    for (int i = 0; i < 2; i++) begin
      n_pend[i] = m_pend[i];
      n_pay[i]  = m_pay[i];
      if (popped && best == i) n_pend[i] = 0;
      if (req_valid[i] && e_rdy[i]) begin
        n_pend[i] = 1;
        n_pay[i]  = req_update[i];
      end
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      m_pay[i] = n_pay[i];
      m_pend[i] = n_pend[i];
      if (flush_valid && n_pend[i] && age(n_pay[i].rob_ticket, rob_head) > age(flush_ticket, rob_head)) begin
        m_pend[i] = 0;
        m_sq = (m_sq < CNT_MAX) ? m_sq + 1 : CNT_MAX;
      end
    end
    if (popped) m_iss = (m_iss < CNT_MAX) ? m_iss + 1 : CNT_MAX;
    @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    rob_head = '0;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_valid", 64'(out_update.valid_jump), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd3);
    check("rst_issue", 64'(issue_count), 64'd0);
    check("rst_squash", 64'(squash_count), 64'd0);
    tick();

    // Same-cycle capture, age order.
    rob_head = 3'd0;
    req_valid = 2'b11; req_update[0] = mk(5); req_update[1] = mk(2);
    tick();
    idle();
    #1 check("order_first", 64'(out_update.rob_ticket), 64'd2);
    tick();
    #1 check("order_second", 64'(out_update.rob_ticket), 64'd5);
    tick();
    #1 check("order_issue", 64'(issue_count), 64'd2);

    // Ticket wrap-around.
    rob_head = 3'd6;
    req_valid = 2'b11; req_update[0] = mk(1); req_update[1] = mk(7);
    tick();
    idle();
    #1 check("wrap_first", 64'(out_update.rob_ticket), 64'd7);
    tick();
    #1 check("wrap_second", 64'(out_update.rob_ticket), 64'd1);
    tick();

    // Flush squashes the younger buffered entry.
    rob_head = 3'd2;
    req_valid = 2'b11; req_update[0] = mk(3); req_update[1] = mk(4);
    tick();
    idle();
    flush_valid = 1'b1; flush_ticket = 3'd3;
    #1 check("flush_issue", 64'(out_update.rob_ticket), 64'd3);
    tick();
    idle();
    #1 check("flush_empty", 64'(out_update.valid_jump), 64'd0);
    check("flush_squash", 64'(squash_count), 64'd1);
    check("flush_issuecnt", 64'(issue_count), 64'd5);
    tick();

    // Back-pressure.
    req_valid = 2'b01; req_update[0] = mk(5); out_ready = 1'b0;
    tick();
    req_valid = 2'b00;
    #1 check("bp_ready0", 64'(req_ready[0]), 64'd0);
    check("bp_hold", 64'(out_update.rob_ticket), 64'd5);
    tick();
    out_ready = 1'b1;
    #1 check("bp_ready1", 64'(req_ready[0]), 64'd1);
    check("bp_valid", 64'(out_update.valid_jump), 64'd1);
    tick();
    #1 check("bp_drained", 64'(out_update.valid_jump), 64'd0);

    // Capture during flush is squashed.
    req_valid = 2'b01; req_update[0] = mk(4);
    tick();
    idle();
    req_valid = 2'b10; req_update[1] = mk(6);
    flush_valid = 1'b1; flush_ticket = 3'd4;
    tick();
    idle();
    #1 check("capflush_empty", 64'(out_update.valid_jump), 64'd0);
    check("capflush_squash", 64'(squash_count), 64'd2);
    check("capflush_issue", 64'(issue_count), 64'd7);
    tick();
    tick();

    // Randomized traffic; counters saturate at 4 bits.
    for (int c = 0; c < 3000; c++) begin
      req_valid = 2'($urandom_range(0, 3));
      for (int i = 0; i < 2; i++) begin
        req_update[i] = pu_t'($urandom);
        req_update[i].valid_jump = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) rob_head = 3'($urandom);
      out_ready    = ($urandom_range(0, 3) != 0);
      flush_valid  = ($urandom_range(0, 6) == 0);
      flush_ticket = $urandom_range(0, 1) ? out_update.rob_ticket : 3'($urandom);
      tick();
    end

    // Asynchronous reset mid-operation.
    req_valid = 2'b11; out_ready = 1'b0; flush_valid = 1'b0;
    req_update[0] = mk(1); req_update[1] = mk(2);
    tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_valid", 64'(out_update.valid_jump), 64'd0);
    check("arst_ready", 64'(req_ready), 64'd3);
    check("arst_issue", 64'(issue_count), 64'd0);
    check("arst_squash", 64'(squash_count), 64'd0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
